axi_axi2bram: RTL and testbench

- AXI4 read master that fetches a contiguous byte range from external memory and writes it, beat by beat, into a local BRAM write port starting at BRAM word 0.
- Reverse path of the BRAM-to-AXI write engine; used to load weights and activations from DDR/HBM into on-chip buffers.
- Splits the transfer into bursts of at most MAX_BURST_LEN beats.
- Keeps up to MAX_OUTSTANDING read bursts in flight.

---
 rtl/axi_axi2bram.sv | 148 ++++++++++++++
 tb/tb_axi_axi2bram.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_axi2bram.sv
// AXI4 read master: fetches a contiguous byte range in MAX_BURST_LEN bursts and
// streams each returned beat into a BRAM write port starting at word 0.
module axi_axi2bram #(
   parameter int AXI_ADDR_WIDTH      = 64,
   parameter int AXI_DATA_WIDTH      = 512,
   parameter int AXI_XFER_SIZE_WIDTH = 32,
   parameter int BRAM_ADDR_WIDTH     = 32,
   parameter int BRAM_DATA_WIDTH     = 512,
   parameter int MAX_BURST_LEN       = 64,
   parameter int MAX_OUTSTANDING     = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_a2b_start,
   output logic                           o_a2b_done,
   input  logic [AXI_ADDR_WIDTH-1:0]      i_a2b_data_addr,
   input  logic [AXI_XFER_SIZE_WIDTH-1:0] i_a2b_data_size_bytes,
   output logic                           m_axi_arvalid,
   input  logic                           m_axi_arready,
   output logic [AXI_ADDR_WIDTH-1:0]      m_axi_araddr,
   output logic [7:0]                     m_axi_arlen,
   input  logic                           m_axi_rvalid,
   output logic                           m_axi_rready,
   input  logic [AXI_DATA_WIDTH-1:0]      m_axi_rdata,
   input  logic                           m_axi_rlast,
   output logic                           o_a2b_wren,
   output logic [BRAM_ADDR_WIDTH-1:0]     o_a2b_wraddr,
   output logic [BRAM_DATA_WIDTH-1:0]     o_a2b_wrdata
);

   localparam int BYTES = AXI_DATA_WIDTH / 8;
   localparam int LOG2B = $clog2(BYTES);
   localparam int BW    = AXI_XFER_SIZE_WIDTH + 1;
   localparam int OW    = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [AXI_ADDR_WIDTH-1:0] BURST_BYTES = AXI_ADDR_WIDTH'(MAX_BURST_LEN * BYTES);
   localparam logic [BW-1:0] MAX_LEN = BW'(MAX_BURST_LEN);
   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

   state_e                       state_q, state_d;
   logic [AXI_ADDR_WIDTH-1:0]    base_q;
   logic [BW-1:0]                total_q, ar_rem_q, ar_bursts_q, beat_cnt_q;
   logic [OW-1:0]                outst_q;
   logic                         arvalid_q;
   logic [AXI_ADDR_WIDTH-1:0]    araddr_q;
   logic [7:0]                   arlen_q;
   logic                         wren_q;
   logic [BRAM_ADDR_WIDTH-1:0]   wr_idx_q, wraddr_q;
   logic [BRAM_DATA_WIDTH-1:0]   wrdata_q;

   logic [BW-1:0] size_ext, total_calc, ar_burst;
   logic          ar_hs, r_hs, r_last_hs, rready;

   // Round-up is done one bit wider so a size near 2^W cannot wrap to zero.
   assign size_ext   = BW'(i_a2b_data_size_bytes) + BW'(BYTES - 1);
   assign total_calc = size_ext >> LOG2B;
   assign ar_burst   = (ar_rem_q > MAX_LEN) ? MAX_LEN : ar_rem_q;
   assign ar_hs      = arvalid_q & m_axi_arready;
   assign r_hs       = m_axi_rvalid & rready;
   assign r_last_hs  = r_hs & m_axi_rlast;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (i_a2b_start) state_d = (total_calc == '0) ? S_DONE : S_BUSY;
         S_BUSY:  if (r_hs && beat_cnt_q == total_q - BW'(1)) state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      rready     = (state_q == S_BUSY);
      o_a2b_done = (state_q == S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_q      <= '0;
         total_q     <= '0;
         ar_rem_q    <= '0;
         ar_bursts_q <= '0;
         beat_cnt_q  <= '0;
         outst_q     <= '0;
         arvalid_q   <= 1'b0;
         araddr_q    <= '0;
         arlen_q     <= '0;
         wren_q      <= 1'b0;
         wr_idx_q    <= '0;
         wraddr_q    <= '0;
         wrdata_q    <= '0;
      end else begin
         wren_q <= 1'b0;
         case (state_q)
            S_IDLE: if (i_a2b_start) begin
               base_q      <= i_a2b_data_addr;
               total_q     <= total_calc;
               ar_rem_q    <= total_calc;
               ar_bursts_q <= '0;
               beat_cnt_q  <= '0;
               outst_q     <= '0;
               wr_idx_q    <= '0;
               arvalid_q   <= 1'b0;
            end
            S_BUSY: begin
               // arvalid drops for one cycle after each handshake so the next
               // request is computed from the updated counters.
               if (ar_hs) begin
                  arvalid_q   <= 1'b0;
                  ar_rem_q    <= ar_rem_q - ar_burst;
                  ar_bursts_q <= ar_bursts_q + BW'(1);
               end else if (!arvalid_q && ar_rem_q != '0 && outst_q < MAX_OUT) begin
                  arvalid_q <= 1'b1;
                  araddr_q  <= base_q + AXI_ADDR_WIDTH'(ar_bursts_q) * BURST_BYTES;
                  arlen_q   <= 8'(ar_burst - BW'(1));
               end
               if (ar_hs && !r_last_hs)
                  outst_q <= outst_q + OW'(1);
               else if (!ar_hs && r_last_hs && outst_q != '0)
                  outst_q <= outst_q - OW'(1);
               if (r_hs) begin
                  beat_cnt_q <= beat_cnt_q + BW'(1);
                  wr_idx_q   <= wr_idx_q + BRAM_ADDR_WIDTH'(1);
                  wren_q     <= 1'b1;
                  wraddr_q   <= wr_idx_q;
                  wrdata_q   <= m_axi_rdata;
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axi_arvalid = arvalid_q;
   assign m_axi_araddr  = araddr_q;
   assign m_axi_arlen   = arlen_q;
   assign m_axi_rready  = rready;
   assign o_a2b_wren    = wren_q;
   assign o_a2b_wraddr  = wraddr_q;
   assign o_a2b_wrdata  = wrdata_q;

endmodule

// File: tb/tb_axi_axi2bram.sv
// Bench for axi_axi2bram: vector table of transfers against a memory/slave model
// with a write scoreboard, plus reset-state and mid-burst reset sequences.
module tb_axi_axi2bram;

   logic          clk, rst_n, start, done;
   logic [63:0]   addr;
   logic [31:0]   size;
   logic          arvalid, arready, rvalid, rready, rlast, wren;
   logic [63:0]   araddr;
   logic [7:0]    arlen;
   logic [511:0]  rdata, wrdata;
   logic [31:0]   wraddr;

   axi_axi2bram dut (
      .clk(clk), .rst_n(rst_n), .i_a2b_start(start), .o_a2b_done(done),
      .i_a2b_data_addr(addr), .i_a2b_data_size_bytes(size),
      .m_axi_arvalid(arvalid), .m_axi_arready(arready), .m_axi_araddr(araddr),
      .m_axi_arlen(arlen), .m_axi_rvalid(rvalid), .m_axi_rready(rready),
      .m_axi_rdata(rdata), .m_axi_rlast(rlast), .o_a2b_wren(wren),
      .o_a2b_wraddr(wraddr), .o_a2b_wrdata(wrdata)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   typedef struct {
      int          size;
      logic [63:0] addr;
      int          ar_pct;
      int          gap_pct;
      int          hold;
      int          exp_beats;
      int          exp_ars;
   } vec_t;
   typedef struct { logic [63:0] a; int len; } ar_t;
   typedef struct { int idx; logic [511:0] d; } wr_t;

   int  tests = 0, fails = 0;
   int  cyc = 0, start_cyc, done_cyc, done_cnt, n_writes, arv_cnt;
   int  outst, max_outst, ar_at_rlast, exp_idx, rbeat, hold_cnt;
   int  ar_pct = 100, gap_pct = 0;
   bit  seen_rlast, ar_hs_n, r_hs_n, rlast_s, ar_wait, done_wren;
   logic [31:0] done_addr;
   ar_t ar_s, ar_log[$], rb_q[$];
   wr_t sbq[$];

   task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   task automatic chkw(input string n, input logic [511:0] act, input logic [511:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", n, act, exp);
      end
   endtask

   function automatic logic [511:0] mem(input logic [63:0] a);
      logic [511:0] d;
      for (int i = 0; i < 16; i++) d[i*32 +: 32] = a[37:6] ^ (32'h9E3779B9 * (i + 1));
      return d;
   endfunction

   // Slave + scoreboard. Inputs set at a negedge decide the handshake at the
   // following posedge; its effects are booked at the negedge after that.
   always @(negedge clk) begin
      if (!rst_n) begin
         rvalid = 0; rlast = 0; arready = 0;
         rb_q.delete(); sbq.delete();
         rbeat = 0; ar_hs_n = 0; r_hs_n = 0; ar_wait = 0; outst = 0;
      end else begin
         wr_t w;
         cyc++;
         if (r_hs_n && rb_q.size() > 0) begin
            sbq.push_back('{exp_idx, mem(rb_q[0].a + 64'(rbeat) * 64)});
            exp_idx++;
            if (rlast_s) begin
               outst--;
               if (!seen_rlast) begin seen_rlast = 1; ar_at_rlast = ar_log.size(); end
               rbeat = 0;
               void'(rb_q.pop_front());
            end else rbeat++;
         end
         if (ar_hs_n) begin
            ar_log.push_back(ar_s);
            rb_q.push_back(ar_s);
            outst++;
            if (outst > max_outst) max_outst = outst;
         end
         if (ar_wait) begin
            chk("ar_hold_addr", araddr, ar_s.a);
            chk("ar_hold_len", {arvalid, arlen}, {1'b1, 8'(ar_s.len)});
         end
         if (arvalid) arv_cnt++;
         if (wren) begin
            n_writes++;
            if (sbq.size() == 0) chk("unexpected_write", 1, 0);
            else begin
               w = sbq.pop_front();
               chk("wraddr", wraddr, 64'(w.idx));
               chkw("wrdata", wrdata, w.d);
            end
         end
         if (done) begin
            done_cnt++; done_cyc = cyc; done_wren = wren; done_addr = wraddr;
         end
         arready = ($urandom_range(0, 99) < ar_pct);
         if (!(rvalid && !r_hs_n)) begin
            rvalid = 0; rlast = 0;
            if (hold_cnt > 0) hold_cnt--;
            else if (rb_q.size() > 0 && $urandom_range(0, 99) >= gap_pct) begin
               rvalid = 1;
               rdata  = mem(rb_q[0].a + 64'(rbeat) * 64);
               rlast  = (rbeat == rb_q[0].len);
            end
         end
         ar_hs_n = arvalid & arready;
         r_hs_n  = rvalid & rready;
         rlast_s = rlast;
         ar_wait = arvalid & !arready;
         ar_s    = '{araddr, int'(arlen)};
      end
   end

   task automatic clr(input vec_t v);
      ar_log.delete();
      n_writes = 0; done_cnt = 0; arv_cnt = 0; max_outst = 0;
      seen_rlast = 0; ar_at_rlast = -1; exp_idx = 0;
      ar_pct = v.ar_pct; gap_pct = v.gap_pct; hold_cnt = v.hold;
   endtask

   task automatic kick(input vec_t v);
      clr(v);
      @(negedge clk); #1;
      start = 1; size = 32'(v.size); addr = v.addr; start_cyc = cyc;
      @(negedge clk); #1;
      start = 0;
   endtask

   task automatic run_vec(input vec_t v);
      int rem;
      kick(v);
      for (int i = 0; i < 5000 && done_cnt == 0; i++) @(posedge clk);
      #1;
      if (done_cnt == 0) chk("done_timeout", 0, 1);
      chk("writes", n_writes, v.exp_beats);
      chk("ar_count", ar_log.size(), v.exp_ars);
      rem = v.exp_beats;
      for (int k = 0; k < v.exp_ars && k < ar_log.size(); k++) begin
         chk("araddr", ar_log[k].a, v.addr + 64'(k) * 4096);
         chk("arlen", ar_log[k].len, (rem > 64 ? 64 : rem) - 1);
         rem -= 64;
      end
      chk("done_count", done_cnt, 1);
      chk("sb_drained", sbq.size(), 0);
      chk("outst_le_max", max_outst <= 4, 1);
      if (v.exp_beats > 0) chk("done_with_last_wr", {done_wren, done_addr}, {1'b1, 32'(v.exp_beats - 1)});
      else begin
         chk("done_latency", done_cyc - start_cyc, 1);
         chk("no_arvalid", arv_cnt, 0);
      end
      if (v.hold > 0) begin
         chk("max_outstanding", max_outst, 4);
         chk("ars_before_rlast", ar_at_rlast, 4);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_arvalid"}, arvalid, 0);
      chk({tag, "_wren"}, wren, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_rready"}, rready, 0);
      chk({tag, "_araddr"}, araddr, 0);
      chk({tag, "_arlen"}, arlen, 0);
      chk({tag, "_wraddr"}, wraddr, 0);
      chk({tag, "_wrdata_nz"}, |wrdata, 0);
   endtask

   vec_t vecs[$];
   vec_t rv;

   initial begin
      rst_n = 0; start = 0; addr = 0; size = 0;
      arready = 0; rvalid = 0; rlast = 0; rdata = '0;
      vecs.push_back('{4096,  64'h1000,  100, 0,  0,  64,   1});
      vecs.push_back('{9000,  64'h0,     100, 0,  0,  141,  3});
      vecs.push_back('{65536, 64'h10000, 100, 0,  50, 1024, 16});
      vecs.push_back('{20000, 64'h40000, 50,  40, 0,  313,  5});
      vecs.push_back('{0,     64'h2000,  100, 0,  0,  0,    0});
      vecs.push_back('{1,     64'h3000,  100, 0,  0,  1,    1});
      vecs.push_back('{128,   64'h5000,  70,  20, 0,  2,    1});
      repeat (3) @(negedge clk);
      #1 chk_zero("reset");
      @(negedge clk); #1 rst_n = 1;
      @(posedge clk); #1;
      foreach (vecs[i]) run_vec(vecs[i]);

      // Reset in the middle of a 64-beat burst, then a fresh short transfer.
      rv = '{4096, 64'h0, 100, 0, 0, 64, 1};
      kick(rv);
      for (int i = 0; i < 500 && n_writes < 10; i++) @(posedge clk);
      if (n_writes < 10) chk("midreset_timeout", 0, 1);
      @(negedge clk); #2 rst_n = 0;
      #1 chk_zero("async_reset");
      repeat (3) @(negedge clk);
      chk("no_done_on_reset", done_cnt, 0);
      #1 rst_n = 1;
      @(posedge clk); #1;
      run_vec('{128, 64'h8000, 100, 0, 0, 2, 1});

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
